// File: rtl/twiddle_pkg.sv
// rtl/twiddle_pkg.sv - shared state encoding, Q-format limits and exponent helper
package twiddle_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } tw_state_e;

  // Largest / smallest signed Q1.(w-1) codes for a w-bit word.
  function automatic longint q_maxpos(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint q_maxneg(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  // Twiddle exponent of butterfly k in stage s of a 2^log2n-point DIT FFT.
  function automatic int unsigned exp_of(input int unsigned k, input int unsigned s,
                                         input int unsigned log2n);
    return (k & ((32'd1 << s) - 32'd1)) << (log2n - 32'd1 - s);
  endfunction

endpackage

// File: rtl/twiddle_rom.sv
// rtl/twiddle_rom.sv - N/2-entry synchronous twiddle ROM (cos, -sin), built at elaboration
module twiddle_rom
  import twiddle_pkg::*;
#(
  parameter int WORDSIZE = 16,
  parameter int LOG2N    = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cs,
  input  logic [LOG2N-2:0]    addr,
  output logic [WORDSIZE-1:0] data_r,
  output logic [WORDSIZE-1:0] data_i
);

  localparam int  DEPTH  = 2 ** (LOG2N - 1);
  localparam real TWO_PI = 6.283185307179586476925;

  // Round to nearest, ties away from zero; +1.0 clamps to the largest code.
  function automatic longint to_q(input real v);
    real    x;
    longint r;
    x = v * (2.0 ** (WORDSIZE - 1));
    if (x >= 0.0) r = longint'($rtoi(x + 0.5));
    else          r = -longint'($rtoi(-x + 0.5));
    if (r > q_maxpos(WORDSIZE)) r = q_maxpos(WORDSIZE);
    if (r < q_maxneg(WORDSIZE)) r = q_maxneg(WORDSIZE);
    return r;
  endfunction

  logic [WORDSIZE-1:0] tab_r [DEPTH];
  logic [WORDSIZE-1:0] tab_i [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_tab
    localparam real ANG = TWO_PI * $itor(g) / (2.0 ** LOG2N);
    assign tab_r[g] = WORDSIZE'(to_q($cos(ANG)));
    assign tab_i[g] = WORDSIZE'(to_q(-$sin(ANG)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= '0;
      data_i <= '0;
    end else if (cs) begin
      data_r <= tab_r[addr];
      data_i <= tab_i[addr];
    end
  end

endmodule

// File: rtl/twiddle_gen.sv
// rtl/twiddle_gen.sv - radix-2 DIT twiddle sequencer: FSM, exponent, 3-stage stallable pipeline
module twiddle_gen
  import twiddle_pkg::*;
#(
  parameter int WORDSIZE  = 16,
  parameter int LOG2N     = 5,
  parameter int STAGEBITS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [STAGEBITS-1:0] stage_num,
  input  logic                 inverse,
  output logic                 busy,
  output logic                 err,
  output logic [WORDSIZE-1:0]  tw_r,
  output logic [WORDSIZE-1:0]  tw_i,
  output logic                 tw_valid,
  output logic                 tw_last,
  input  logic                 tw_ready
);

  localparam int                  EW       = LOG2N - 1;
  localparam int                  HALF     = 2 ** EW;
  localparam logic [EW-1:0]       K_LAST   = EW'(HALF - 1);
  localparam logic [STAGEBITS:0]  NSTAGE   = (STAGEBITS + 1)'(LOG2N);
  localparam logic [WORDSIZE-1:0] MAXPOS_W = WORDSIZE'(q_maxpos(WORDSIZE));
  localparam logic [WORDSIZE-1:0] MAXNEG_W = WORDSIZE'(q_maxneg(WORDSIZE));

  tw_state_e            state_q, state_d;
  logic [EW-1:0]        k_q, k_d;
  logic [STAGEBITS-1:0] s_q;
  logic                 inv_q;

  logic [EW-1:0]        addr_q, addr_d;
  logic                 a_v, a_last;
  logic                 r_v, r_last;
  logic [WORDSIZE-1:0]  rom_r, rom_i, conj_i;

  logic stall, issue, rom_cs, start_ok, start_bad, accept_last;

  assign busy        = (state_q != IDLE);
  assign stall       = tw_valid & ~tw_ready;
  assign start_ok    = start & (state_q == IDLE) & ({1'b0, stage_num} < NSTAGE);
  assign start_bad   = start & (state_q == IDLE) & ({1'b0, stage_num} >= NSTAGE);
  assign issue       = (state_q == RUN) & ~stall;
  assign rom_cs      = (state_q != IDLE) & ~stall;
  assign accept_last = tw_valid & tw_ready & tw_last;
  assign addr_d      = EW'(exp_of(32'(k_q), 32'(s_q), LOG2N));
  assign conj_i      = (rom_i == MAXNEG_W) ? MAXPOS_W : (WORDSIZE'(0) - rom_i);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        // k=0 is issued on the start edge itself, so RUN resumes at k=1.
        if (start_ok) begin
          state_d = RUN;
          k_d     = EW'(1);
        end
      end
      RUN: begin
        if (!stall) begin
          k_d = k_q + EW'(1);
          if (k_q == K_LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (accept_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      s_q     <= '0;
      inv_q   <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      err     <= start_bad;
      if (start_ok) begin
        s_q   <= stage_num;
        inv_q <= inverse;
      end
    end
  end

  // Address stage: exponent of k=0 is always 0, independent of stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      a_v    <= 1'b0;
      a_last <= 1'b0;
    end else if (start_ok) begin
      addr_q <= '0;
      a_v    <= 1'b1;
      a_last <= 1'b0;
    end else if (!stall) begin
      addr_q <= addr_d;
      a_v    <= issue;
      a_last <= issue & (k_q == K_LAST);
    end
  end

  twiddle_rom #(
    .WORDSIZE (WORDSIZE),
    .LOG2N    (LOG2N)
  ) u_rom (
    .clk    (clk),
    .rst_n  (rst_n),
    .cs     (rom_cs),
    .addr   (addr_q),
    .data_r (rom_r),
    .data_i (rom_i)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v      <= 1'b0;
      r_last   <= 1'b0;
      tw_valid <= 1'b0;
      tw_last  <= 1'b0;
      tw_r     <= '0;
      tw_i     <= '0;
    end else if (!stall) begin
      r_v      <= a_v;
      r_last   <= a_last;
      tw_valid <= r_v;
      tw_last  <= r_last;
      if (r_v) begin
        tw_r <= rom_r;
        tw_i <= inv_q ? conj_i : rom_i;
      end
    end
  end

endmodule

// File: doc/twiddle_gen.md
# twiddle_gen

Parametrised twiddle-factor sequencer for the radix-2 DIT FFT datapath. On a start pulse for a given stage, it walks all N/2 butterflies of that stage and computes each twiddle exponent. It reads W_N^e from an internal synchronous ROM and streams (real, imag) words to the butterfly unit with valid/ready flow control. It also supports inverse-transform conjugation with saturation.

## Interface
Parameters:
- WORDSIZE, 16: twiddle word width, signed Q1.(WORDSIZE-1)
- LOG2N, 5: log2 of FFT size; N = 2^LOG2N, ROM depth N/2
- STAGEBITS, 3: width of stage_num; must satisfy 2^STAGEBITS >= LOG2N

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle request to begin a stage sequence
- stage_num  in  STAGEBITS  stage index, sampled with start
- inverse  in  1  conjugate outputs (IFFT), sampled with start
- busy  out  1  sequence in progress
- err  out  1  one-cycle pulse: start with stage_num >= LOG2N
- tw_r  out  WORDSIZE  twiddle real part
- tw_i  out  WORDSIZE  twiddle imaginary part
- tw_valid  out  1  tw_r/tw_i hold a valid twiddle
- tw_last  out  1  qualifies the final twiddle of the stage (k = N/2-1)
- tw_ready  in  1  consumer accepts the word when tw_valid & tw_ready

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start with a legal stage: latch stage s and inverse, set k=0, assert busy.
  - IDLE + start with an illegal stage: pulse err, stay in IDLE.
  - start while busy is ignored; no err.
  - RUN issues one ROM address per non-stalled cycle. After issuing k = N/2-1, go to DRAIN.
  - DRAIN -> IDLE when the last word is accepted (tw_valid & tw_ready & tw_last); busy drops on that edge.
- Exponent: e = (k & (2^s - 1)) << (LOG2N-1-s), width LOG2N-1. Stage 0 gives all e=0; stage LOG2N-1 gives e=k.
- ROM entry e holds cos(2πe/N) in the real part and -sin(2πe/N) in the imaginary part, rounded to Q1.15. -1.0 is encoded as -2^(WORDSIZE-1).
- Inverse: tw_i = -rom_i, saturating. -(-2^(WORDSIZE-1)) becomes 2^(WORDSIZE-1)-1. tw_r is unchanged.
- Pipeline: address register -> ROM data register -> output register.
  - Global stall = tw_valid & ~tw_ready.
  - During stall, the counter, ROM enable and all pipeline registers hold.
  - No words are dropped or duplicated.
- The ROM enable is deasserted in IDLE and during stall.

## Timing
- Reset values: busy=0, err=0, tw_valid=0, tw_last=0, tw_r=0, tw_i=0. Internally, FSM=IDLE and k=0.
- Reset assertion clears all outputs immediately, asynchronously, including mid-sequence. After release the block sits in IDLE; the sequence is not resumed.
- Latency: start sampled at edge E0 -> first tw_valid after edge E2.
- Throughput: with tw_ready held high, one word per cycle, so N/2 consecutive valid cycles.
- tw_ready may toggle arbitrarily. Outputs are stable while stalled.
- err pulses exactly one cycle, the cycle after the offending start.
- A start on the same cycle the last word is accepted is ignored, because busy is still 1 on that cycle.

## Structure
- Shared package twiddle_pkg holds:
  - the state enum (IDLE/RUN/DRAIN)
  - the Q-format constants MAXPOS/MAXNEG
  - the exponent function exp_of(k, s)
- Sub-module twiddle_rom: N/2 x 2·WORDSIZE synchronous-read ROM with chip-select (cs, addr -> data_r, data_i, 1-cycle latency). Output holds when cs=0. Contents are generated from LOG2N at elaboration.
- Top level: FSM, k counter, exponent logic, stall control, conjugate/saturation, output register.

## Test plan
- N=32, stage 4, inverse=0, tw_ready=1: 16 words, with exponents 0..15 in order. k=8 gives (0, -32768). tw_last only on the 16th word. First tw_valid 2 cycles after start.
- Stage 2, inverse=0: exponents repeat 0,4,8,12 four times. k=5 gives e=4, i.e. (23170, -23170).
- Stage 4, inverse=1: k=8 gives tw_i=+32767 (saturated). k=4 gives (23170, 23170). k=0 gives (32767, 0).
- Stage 4 with random tw_ready (~50% duty): the consumer captures exactly 16 words, in order, with no duplicates. Outputs are stable on every stalled cycle.
- start with stage_num=5: err pulses one cycle, busy stays 0, no tw_valid. A start during RUN is ignored and the word count stays 16.
- rst_n asserted at word 7 of a run: outputs clear immediately. After release, a new start with stage 0 yields 16 words of (32767, 0).
